// File: rtl/bsg_mem_1rw_sync_banked_mask_pkg.sv
// Shared types for the banked byte-masked 1rw RAM: read-return channel state
// and the flag view of it used by the top-level output logic.
package bsg_mem_1rw_sync_banked_mask_pkg;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_FRESH = 2'd1,
    RD_HOLD  = 2'd2
  } rd_state_e;

  typedef struct packed {
    logic fresh_v;
    logic hold_v;
  } rd_flags_s;

endpackage

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// One physical bank: synchronous single-port RAM with per-byte write enables.
// The output register only changes on a read, like a typical SRAM macro.
module bsg_mem_1rw_sync_mask_write_byte #(
  parameter int els_p    = 256,
  parameter int width_p  = 64,
  parameter int harden_p = 1,
  localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int mask_width_lp = width_p / 8
) (
  input  logic                     clk_i,
  input  logic                     v_i,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  input  logic [mask_width_lp-1:0] w_mask_i,
  output logic [width_p-1:0]       data_o
);

  logic [width_p-1:0] r_mem [els_p];
  logic [width_p-1:0] r_data;

  if ((harden_p != 0) && (harden_p != 1)) begin : g_bad_harden
    $error("harden_p must be 0 or 1");
  end

  always_ff @(posedge clk_i) begin
    if (v_i & w_i) begin
      for (int b = 0; b < mask_width_lp; b++) begin
        if (w_mask_i[b]) r_mem[addr_i][b*8 +: 8] <= data_i[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (v_i & ~w_i) r_data <= r_mem[addr_i];
  end

  assign data_o = r_data;

endmodule

// File: rtl/bsg_mem_1rw_sync_banked_mask.sv
// Banked, byte-masked single-port RAM with a valid/yumi read-return channel.
// Handshake: a request is taken when v_i & ready_o; read data is consumed when data_v_o & yumi_i.
module bsg_mem_1rw_sync_banked_mask
  import bsg_mem_1rw_sync_banked_mask_pkg::*;
#(
  parameter int width_p     = 64,
  parameter int els_p       = 1024,
  parameter int num_banks_p = 4,
  parameter int harden_p    = 1,
  localparam int addr_width_lp     = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int bank_sel_width_lp = (num_banks_p > 1) ? $clog2(num_banks_p) : 1,
  localparam int mask_width_lp     = width_p / 8
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     v_i,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  input  logic [mask_width_lp-1:0] w_mask_i,
  output logic                     ready_o,
  output logic [width_p-1:0]       data_o,
  output logic                     data_v_o,
  input  logic                     yumi_i
);

  localparam int sel_bits_lp          = $clog2(num_banks_p);
  localparam int bank_els_lp          = els_p / num_banks_p;
  localparam int bank_addr_width_lp   = (bank_els_lp > 1) ? $clog2(bank_els_lp) : 1;

  if (((width_p % 8) != 0) || (num_banks_p < 1) || ((els_p % num_banks_p) != 0)
      || ((num_banks_p & (num_banks_p - 1)) != 0)) begin : g_bad_params
    $error("illegal parameters: width_p%%8, els_p%%num_banks_p or non-power-of-two banks");
  end

  rd_state_e                     r_state;
  rd_state_e                     w_state_next;
  rd_flags_s                     w_flags;
  logic [width_p-1:0]            r_hold;
  logic [bank_sel_width_lp-1:0]  r_bank_sel;
  logic [bank_sel_width_lp-1:0]  w_bank_sel;
  logic [bank_addr_width_lp-1:0] w_bank_addr;
  logic [num_banks_p-1:0]        w_bank_v;
  logic [width_p-1:0]            w_bank_data [num_banks_p];
  logic [width_p-1:0]            w_bank_out;
  logic                          w_accept;
  logic                          w_rd;

  // Low-order interleave: consecutive words land in consecutive banks.
  if (num_banks_p == 1) begin : g_one_bank
    assign w_bank_sel = '0;
  end else begin : g_multi_bank
    assign w_bank_sel = addr_i[bank_sel_width_lp-1:0];
  end
  assign w_bank_addr = bank_addr_width_lp'(addr_i >> sel_bits_lp);

  assign w_flags.fresh_v = (r_state == RD_FRESH);
  assign w_flags.hold_v  = (r_state == RD_HOLD);
  assign data_v_o        = w_flags.fresh_v | w_flags.hold_v;
  assign ready_o         = reset_n_i & (~data_v_o | yumi_i);
  assign w_accept        = v_i & ready_o;
  assign w_rd            = w_accept & ~w_i;

  for (genvar b = 0; b < num_banks_p; b++) begin : g_bank
    assign w_bank_v[b] = w_accept & (w_bank_sel == bank_sel_width_lp'(b));

    bsg_mem_1rw_sync_mask_write_byte #(
      .els_p   (bank_els_lp),
      .width_p (width_p),
      .harden_p(harden_p)
    ) u_bank (
      .clk_i   (clk_i),
      .v_i     (w_bank_v[b]),
      .w_i     (w_i),
      .addr_i  (w_bank_addr),
      .data_i  (data_i),
      .w_mask_i(w_mask_i),
      .data_o  (w_bank_data[b])
    );
  end

  assign w_bank_out = w_bank_data[r_bank_sel];
  assign data_o     = w_flags.fresh_v ? w_bank_out : r_hold;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RD_IDLE:  if (w_rd) w_state_next = RD_FRESH;
      RD_FRESH: begin
        if (w_rd)        w_state_next = RD_FRESH;
        else if (yumi_i) w_state_next = RD_IDLE;
        else             w_state_next = RD_HOLD;
      end
      RD_HOLD:  if (yumi_i) w_state_next = w_rd ? RD_FRESH : RD_IDLE;
      default:  w_state_next = RD_IDLE;
    endcase
  end

  // The hold register copies every fresh word, so it doubles as the latch-last value.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state    <= RD_IDLE;
      r_hold     <= '0;
      r_bank_sel <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_flags.fresh_v) r_hold <= w_bank_out;
      if (w_rd) r_bank_sel <= w_bank_sel;
    end
  end

  a_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> data_v_o)
    else $error("yumi_i asserted while data_v_o=0");

endmodule

// File: tb/tb_bsg_mem_1rw_sync_banked_mask.sv
// Bench for the banked byte-masked RAM: directed scenarios plus a randomized
// run checked against a word-array memory and a pending-read queue.
module tb_bsg_mem_1rw_sync_banked_mask;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        v_i, w_i, yumi_i;
  logic [9:0]  addr_i;
  logic [63:0] data_i;
  logic [7:0]  w_mask_i;
  logic        ready_o, data_v_o;
  logic [63:0] data_o;

  logic [63:0] mem_ref [1024];
  logic [63:0] exp_q[$];
  logic [63:0] last_data;
  logic        exp_ready, obs_ready;
  logic [3:0]  obs_bank_v;
  int          n_checks = 0;
  int          n_errors = 0;

  bsg_mem_1rw_sync_banked_mask #(
    .width_p(64), .els_p(1024), .num_banks_p(4), .harden_p(1)
  ) dut (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .v_i      (v_i),
    .w_i      (w_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .w_mask_i (w_mask_i),
    .ready_o  (ready_o),
    .data_o   (data_o),
    .data_v_o (data_v_o),
    .yumi_i   (yumi_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One cycle: drive, sample ready, clock, update the reference; ends 1 ns after the edge.
  task automatic step(input logic v, input logic w, input logic [9:0] a,
                      input logic [63:0] d, input logic [7:0] m, input logic y);
    logic acc;
    v_i = v; w_i = w; addr_i = a; data_i = d; w_mask_i = m; yumi_i = y;
    #1;
    obs_ready  = ready_o;
    obs_bank_v = dut.w_bank_v;
    exp_ready  = (exp_q.size() == 0) || y;
    acc        = v && exp_ready;
    @(posedge clk_i);
    if (y && (exp_q.size() > 0)) last_data = exp_q.pop_front();
    if (acc && w) begin
      for (int b = 0; b < 8; b++)
        if (m[b]) mem_ref[a][b*8 +: 8] = d[b*8 +: 8];
    end else if (acc) begin
      exp_q.push_back(mem_ref[a]);
    end
    #1;
    v_i = 1'b0; yumi_i = 1'b0;
  endtask

  task automatic test_reset;
    reset_n_i = 1'b0; v_i = 0; w_i = 0; yumi_i = 0; addr_i = '0; data_i = '0; w_mask_i = '0;
    last_data = '0;
    #2;
    n_checks++;
    if (ready_o !== 1'b0) begin n_errors++; $display("FAIL reset_ready: got %b want 0", ready_o); end
    n_checks++;
    if (data_v_o !== 1'b0) begin n_errors++; $display("FAIL reset_data_v: got %b want 0", data_v_o); end
    n_checks++;
    if (data_o !== 64'h0) begin n_errors++; $display("FAIL reset_data: got %h want 0", data_o); end
    repeat (2) @(posedge clk_i);
    #1 reset_n_i = 1'b1;
  endtask

  task automatic test_write_read;
    step(1, 1, 10'd5, 64'h1122334455667788, 8'hFF, 0);
    n_checks++;
    if (data_v_o !== 1'b0) begin n_errors++; $display("FAIL wr_no_valid: got %b want 0", data_v_o); end
    step(1, 0, 10'd5, 64'h0, 8'h00, 0);
    n_checks++;
    if (data_v_o !== 1'b1) begin n_errors++; $display("FAIL rd_valid: got %b want 1", data_v_o); end
    n_checks++;
    if (data_o !== 64'h1122334455667788) begin
      n_errors++; $display("FAIL rd_data: got %h want 1122334455667788", data_o);
    end
    step(0, 0, 10'd0, 64'h0, 8'h00, 1);
    n_checks++;
    if (data_v_o !== 1'b0) begin n_errors++; $display("FAIL rd_valid_drop: got %b want 0", data_v_o); end
  endtask

  task automatic test_masked_write;
    step(1, 1, 10'd6, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0);
    step(1, 1, 10'd6, 64'h0, 8'h0F, 0);
    step(1, 0, 10'd6, 64'h0, 8'h00, 0);
    n_checks++;
    if (data_o !== 64'hFFFFFFFF00000000) begin
      n_errors++; $display("FAIL mask_data: got %h want ffffffff00000000", data_o);
    end
    step(0, 0, 10'd0, 64'h0, 8'h00, 1);
  endtask

  task automatic test_backpressure;
    step(1, 0, 10'd5, 64'h0, 8'h00, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 10'd6, 64'h0, 8'h00, 0);
      n_checks++;
      if (obs_ready !== 1'b0) begin n_errors++; $display("FAIL stall_ready[%0d]: got %b want 0", i, obs_ready); end
      n_checks++;
      if (data_v_o !== 1'b1 || data_o !== 64'h1122334455667788) begin
        n_errors++; $display("FAIL stall_data[%0d]: got v=%b %h want v=1 1122334455667788", i, data_v_o, data_o);
      end
    end
    step(0, 0, 10'd0, 64'h0, 8'h00, 1);
    n_checks++;
    if (obs_ready !== 1'b1) begin n_errors++; $display("FAIL yumi_ready: got %b want 1", obs_ready); end
    n_checks++;
    if (data_v_o !== 1'b0) begin n_errors++; $display("FAIL yumi_drain: got %b want 0", data_v_o); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] vals [4];
    for (int i = 0; i < 4; i++) begin
      vals[i] = {$urandom(), $urandom()};
      step(1, 1, 10'(i), vals[i], 8'hFF, 0);
    end
    for (int i = 0; i < 5; i++) begin
      step(i < 4, 0, 10'(i), 64'h0, 8'h00, i > 0);
      if (i < 4) begin
        n_checks++;
        if (obs_bank_v !== 4'(1 << i)) begin
          n_errors++; $display("FAIL stream_bank_en[%0d]: got %b want %b", i, obs_bank_v, 4'(1 << i));
        end
        n_checks++;
        if (data_v_o !== 1'b1 || data_o !== vals[i]) begin
          n_errors++; $display("FAIL stream_data[%0d]: got v=%b %h want v=1 %h", i, data_v_o, data_o, vals[i]);
        end
      end else begin
        n_checks++;
        if (data_v_o !== 1'b0) begin n_errors++; $display("FAIL stream_end: got %b want 0", data_v_o); end
      end
    end
  endtask

  task automatic test_latch_last;
    step(1, 1, 10'd9, 64'hABAB_ABAB_ABAB_ABAB, 8'hFF, 0);
    step(1, 0, 10'd9, 64'h0, 8'h00, 0);
    step(0, 0, 10'd0, 64'h0, 8'h00, 1);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (data_v_o !== 1'b0 || data_o !== 64'hABAB_ABAB_ABAB_ABAB) begin
        n_errors++; $display("FAIL latch_last[%0d]: got v=%b %h want v=0 abababababababab", i, data_v_o, data_o);
      end
      step(0, 0, 10'd0, 64'h0, 8'h00, 0);
    end
  endtask

  task automatic test_reset_mid_read;
    v_i = 1; w_i = 0; addr_i = 10'd5;
    #1 reset_n_i = 1'b0;
    #1;
    n_checks++;
    if (data_v_o !== 1'b0 || data_o !== 64'h0 || ready_o !== 1'b0) begin
      n_errors++; $display("FAIL mid_reset_now: got v=%b d=%h rdy=%b want 0 0 0", data_v_o, data_o, ready_o);
    end
    @(posedge clk_i);
    #1 v_i = 0;
    exp_q.delete();
    last_data = '0;
    reset_n_i = 1'b1;
    step(0, 0, 10'd0, 64'h0, 8'h00, 0);
    n_checks++;
    if (data_v_o !== 1'b0 || data_o !== 64'h0) begin
      n_errors++; $display("FAIL mid_reset_after: got v=%b %h want v=0 0", data_v_o, data_o);
    end
    step(1, 0, 10'd5, 64'h0, 8'h00, 0);
    n_checks++;
    if (data_v_o !== 1'b1 || data_o !== 64'h1122334455667788) begin
      n_errors++; $display("FAIL mid_reset_reread: got v=%b %h want v=1 1122334455667788", data_v_o, data_o);
    end
    step(0, 0, 10'd0, 64'h0, 8'h00, 1);
  endtask

  task automatic test_random;
    logic v, w, y;
    logic [63:0] want;
    for (int a = 0; a < 32; a++) step(1, 1, 10'(a), {$urandom(), $urandom()}, 8'hFF, 0);
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      w = $urandom_range(0, 1);
      y = (exp_q.size() > 0) && ($urandom_range(0, 2) != 0);
      step(v, w, 10'($urandom_range(0, 31)), {$urandom(), $urandom()}, 8'($urandom_range(0, 255)), y);
      n_checks++;
      if (obs_ready !== exp_ready) begin
        n_errors++; $display("FAIL rand_ready[%0d]: got %b want %b", i, obs_ready, exp_ready);
      end
      want = (exp_q.size() > 0) ? exp_q[0] : last_data;
      n_checks++;
      if (data_v_o !== (exp_q.size() > 0) || data_o !== want) begin
        n_errors++; $display("FAIL rand_out[%0d]: got v=%b %h want v=%b %h", i, data_v_o, data_o, exp_q.size() > 0, want);
      end
    end
    while (exp_q.size() > 0) step(0, 0, 10'd0, 64'h0, 8'h00, 1);
    n_checks++;
    if (data_v_o !== 1'b0 || data_o !== last_data) begin
      n_errors++; $display("FAIL rand_drain: got v=%b %h want v=0 %h", data_v_o, data_o, last_data);
    end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_masked_write;
    test_backpressure;
    test_back_to_back;
    test_latch_last;
    test_reset_mid_read;
    test_random;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
